// File: rtl/rfm_act_cnt_table.sv
// rfm_act_cnt_table: per-entry ACT counter table with RFM issue FSM (scan for max, request, clear)
// Ports: clk, rstn (sync, active-low); act_valid/act_idx count one ACT per cycle;
// cnt_table_flat exports the registered table (entry i at [i*CNT_SIZE +: CNT_SIZE]);
// rfm_req/rfm_idx/rfm_cnt/rfm_ack form the RFM handshake; busy is high outside IDLE.
// Optional macro RFM_ACT_CNT_TABLE_STATS_EN adds rfm_issue_cnt and sat_seen outputs.
module rfm_act_cnt_table #(
    parameter int NUM_ENTRY = 64,
    parameter int CNT_SIZE  = 32,
    parameter int IDX_W     = 6,
    parameter int RFM_TH    = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          act_valid,
    input  logic [IDX_W-1:0]              act_idx,
    output logic [NUM_ENTRY*CNT_SIZE-1:0] cnt_table_flat,
    output logic                          rfm_req,
    output logic [IDX_W-1:0]              rfm_idx,
    output logic [CNT_SIZE-1:0]           rfm_cnt,
    input  logic                          rfm_ack,
    output logic                          busy
`ifdef RFM_ACT_CNT_TABLE_STATS_EN
    ,
    output logic [CNT_SIZE-1:0]           rfm_issue_cnt,
    output logic                          sat_seen
`endif
);
    typedef enum logic [1:0] {IDLE, SCAN, REQ, CLEAR} state_t;
    localparam logic [CNT_SIZE-1:0] TH   = CNT_SIZE'(RFM_TH);
    localparam logic [CNT_SIZE-1:0] CMAX = '1;
    localparam logic [CNT_SIZE-1:0] ONE  = CNT_SIZE'(1);
    localparam logic [IDX_W-1:0]    LAST = IDX_W'(NUM_ENTRY - 1);
    state_t               state_q, state_d;
    logic [CNT_SIZE-1:0]  cnt_q [NUM_ENTRY];
    logic [CNT_SIZE-1:0]  cnt_d [NUM_ENTRY];
    logic [CNT_SIZE-1:0]  raac_q, raac_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     best_idx_q, best_idx_d;
    logic [CNT_SIZE-1:0]  best_cnt_q, best_cnt_d;
    // Clear happens before the same-cycle ACT increment, so an ACT to the cleared entry leaves it at 1.
    always_comb begin
        for (int i = 0; i < NUM_ENTRY; i++) begin
            cnt_d[i] = (state_q == CLEAR && best_idx_q == IDX_W'(i)) ? '0 : cnt_q[i];
            if (act_valid && act_idx == IDX_W'(i) && cnt_d[i] != CMAX) cnt_d[i] = cnt_d[i] + ONE;
        end
    end
    always_comb begin
        raac_d = (state_q == CLEAR) ? ((raac_q >= TH) ? raac_q - TH : '0) : raac_q;
        if (act_valid && raac_d != CMAX) raac_d = raac_d + ONE;
    end
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        best_idx_d = best_idx_q;
        best_cnt_d = best_cnt_q;
        case (state_q)
            IDLE: if (raac_q >= TH) begin
                state_d    = SCAN;
                ptr_d      = '0;
                best_idx_d = '0;
                best_cnt_d = '0;
            end
            SCAN: begin
                if (cnt_q[ptr_q] > best_cnt_q) begin
                    best_idx_d = ptr_q;
                    best_cnt_d = cnt_q[ptr_q];
                end
                ptr_d   = ptr_q + 1'b1;
                state_d = (ptr_q == LAST) ? REQ : SCAN;
            end
            REQ:     state_d = rfm_ack ? CLEAR : REQ;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            raac_q     <= '0;
            ptr_q      <= '0;
            best_idx_q <= '0;
            best_cnt_q <= '0;
            for (int i = 0; i < NUM_ENTRY; i++) cnt_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            raac_q     <= raac_d;
            ptr_q      <= ptr_d;
            best_idx_q <= best_idx_d;
            best_cnt_q <= best_cnt_d;
            for (int i = 0; i < NUM_ENTRY; i++) cnt_q[i] <= cnt_d[i];
        end
    end
    always_comb begin
        for (int i = 0; i < NUM_ENTRY; i++) cnt_table_flat[i*CNT_SIZE +: CNT_SIZE] = cnt_q[i];
    end
    // The best-so-far registers only change during SCAN, so they hold steady throughout REQ and CLEAR.
    assign rfm_req = (state_q == REQ);
    assign rfm_idx = best_idx_q;
    assign rfm_cnt = best_cnt_q;
    assign busy    = (state_q != IDLE);
`ifdef RFM_ACT_CNT_TABLE_STATS_EN
    logic [CNT_SIZE-1:0] issue_q, issue_d;
    logic                sat_q, sat_d;
    always_comb begin
        issue_d = (rfm_req && rfm_ack && issue_q != CMAX) ? issue_q + ONE : issue_q;
        sat_d   = sat_q | (raac_d == CMAX);
        for (int i = 0; i < NUM_ENTRY; i++) sat_d = sat_d | (cnt_d[i] == CMAX);
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            issue_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            issue_q <= issue_d;
            sat_q   <= sat_d;
        end
    end
    assign rfm_issue_cnt = issue_q;
    assign sat_seen      = sat_q;
`endif
endmodule

// File: tb/tb_rfm_act_cnt_table.sv
// tb_rfm_act_cnt_table: directed and random checks of rfm_act_cnt_table against a behavioural model
module tb_rfm_act_cnt_table;
    localparam longint CMAX = 64'hFFFF_FFFF;
    localparam int     N    = 64;
    localparam longint TH   = 16;
    logic          clk = 1'b0;
    logic          rstn0 = 1'b0, av0 = 1'b0, ack0 = 1'b0;
    logic [5:0]    ai0 = '0;
    logic [2047:0] flat0;
    logic          req0, busy0;
    logic [5:0]    idx0;
    logic [31:0]   cnt0;
    logic          rstn1 = 1'b0, av1 = 1'b0, ack1 = 1'b0;
    logic [1:0]    ai1 = '0;
    logic [15:0]   flat1;
    logic          req1, busy1;
    logic [1:0]    idx1;
    logic [3:0]    cnt1;
    int            errors = 0, checks = 0;
    longint        ent [N];
    longint        nent [N];
    longint        raac, nraac, best_cnt;
    int            scan_pos, best_idx;
    bit            in_req, in_clr;

    always #5 clk = ~clk;

    rfm_act_cnt_table u0 (
        .clk(clk), .rstn(rstn0), .act_valid(av0), .act_idx(ai0), .cnt_table_flat(flat0),
        .rfm_req(req0), .rfm_idx(idx0), .rfm_cnt(cnt0), .rfm_ack(ack0), .busy(busy0)
    );
    rfm_act_cnt_table #(.NUM_ENTRY(4), .CNT_SIZE(4), .IDX_W(2), .RFM_TH(15)) u1 (
        .clk(clk), .rstn(rstn1), .act_valid(av1), .act_idx(ai1), .cnt_table_flat(flat1),
        .rfm_req(req1), .rfm_idx(idx1), .rfm_cnt(cnt1), .rfm_ack(ack1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: each entry is examined once, in index order, one per cycle after the trigger.
    task automatic model_step();
        if (!rstn0) begin
            foreach (ent[i]) ent[i] = 0;
            raac = 0; scan_pos = -1; in_req = 0; in_clr = 0; best_idx = 0; best_cnt = 0;
            return;
        end
        nent = ent;
        nraac = raac;
        if (in_clr) begin
            nent[best_idx] = 0;
            nraac = (raac > TH) ? raac - TH : 0;
        end
        if (av0) begin
            if (nent[ai0] < CMAX) nent[ai0]++;
            if (nraac < CMAX) nraac++;
        end
        if (in_clr) in_clr = 0;
        else if (in_req) begin
            if (ack0) begin in_req = 0; in_clr = 1; end
        end else if (scan_pos >= 0) begin
            if (ent[scan_pos] > best_cnt) begin best_idx = scan_pos; best_cnt = ent[scan_pos]; end
            scan_pos++;
            if (scan_pos == N) begin scan_pos = -1; in_req = 1; end
        end else if (raac >= TH) begin
            scan_pos = 0; best_idx = 0; best_cnt = 0;
        end
        ent = nent;
        raac = nraac;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic chk_model();
        int k;
        k = $urandom_range(0, N - 1);
        chk("m_req", req0, in_req);
        chk("m_busy", busy0, in_req || in_clr || scan_pos >= 0);
        if (in_req) begin
            chk("m_idx", idx0, best_idx);
            chk("m_cnt", cnt0, best_cnt);
        end
        chk("m_ent", flat0[k*32 +: 32], ent[k]);
    endtask

    task automatic chk_all();
        for (int i = 0; i < N; i++) chk("m_all", flat0[i*32 +: 32], ent[i]);
    endtask

    task automatic do_reset();
        rstn0 = 1'b0; rstn1 = 1'b0;
        tick();
        rstn0 = 1'b1; rstn1 = 1'b1;
    endtask

    task automatic act0(input int idx, input int n);
        for (int i = 0; i < n; i++) begin
            av0 = 1'b1; ai0 = 6'(idx);
            tick();
            chk_model();
        end
        av0 = 1'b0;
    endtask

    task automatic wait_req0(input int lim);
        int n = 0;
        while (!req0 && n < lim) begin tick(); chk_model(); n++; end
        chk("req0_timeout", req0, 1);
    endtask

    task automatic wait_req1(input int lim);
        int n = 0;
        while (!req1 && n < lim) begin tick(); n++; end
        chk("req1_timeout", req1, 1);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        chk("rst_flat", flat0 === '0, 1);
        chk("rst_req", req0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_idx", idx0, 0);
        chk("rst_cnt", cnt0, 0);
        act0(5, 3);
        tick();
        chk("e5", flat0[5*32 +: 32], 3);
        chk("e5_busy", busy0, 0);
        chk_model();

        do_reset();
        act0(7, 10);
        act0(40, 6);
        for (int i = 0; i < 64; i++) begin tick(); chk_model(); end
        chk("lat_pre", req0, 0);
        tick();
        chk("lat", req0, 1);
        chk("sel_idx", idx0, 7);
        chk("sel_cnt", cnt0, 10);
        for (int i = 0; i < 5; i++) begin tick(); chk("hold_req", req0, 1); chk("hold_idx", idx0, 7); chk_model(); end
        ack0 = 1'b1;
        tick();
        ack0 = 1'b0;
        chk("clr_req", req0, 0);
        chk("clr_busy", busy0, 1);
        chk_model();
        tick();
        chk("e7_clr", flat0[7*32 +: 32], 0);
        chk("e40_keep", flat0[40*32 +: 32], 6);
        chk("post_busy", busy0, 0);
        chk_model();

        do_reset();
        act0(9, 8);
        act0(3, 8);
        wait_req0(80);
        chk("tie_idx", idx0, 3);
        chk("tie_cnt", cnt0, 8);
        ack0 = 1'b1;
        tick();
        ack0 = 1'b0; av0 = 1'b1; ai0 = 6'd3;
        tick();
        av0 = 1'b0;
        chk("clr_act_e3", flat0[3*32 +: 32], 1);
        chk("clr_act_busy", busy0, 0);
        chk_model();
        tick();
        chk("clr_act_noscan", busy0, 0);
        chk_model();

        for (int i = 0; i < 20; i++) begin av1 = 1'b1; ai1 = 2'd0; tick(); end
        av1 = 1'b0;
        chk("sat_e0", flat1[3:0], 15);
        wait_req1(20);
        chk("sat_idx", idx1, 0);
        chk("sat_cnt", cnt1, 15);
        ack1 = 1'b1;
        tick();
        ack1 = 1'b0;
        tick();
        chk("sat_clr", flat1[3:0], 0);
        chk("sat_idle", busy1, 0);
        for (int i = 0; i < 15; i++) begin av1 = 1'b1; ai1 = 2'd0; tick(); end
        av1 = 1'b0;
        tick();
        chk("scan_busy", busy1, 1);
        rstn1 = 1'b0;
        tick();
        rstn1 = 1'b1;
        chk("mid_rst_flat", flat1, 0);
        chk("mid_rst_req", req1, 0);
        chk("mid_rst_busy", busy1, 0);
        chk("mid_rst_idx", idx1, 0);
        chk("mid_rst_cnt", cnt1, 0);
        tick();
        chk("mid_rst_idle", busy1, 0);

        do_reset();
        for (int c = 0; c < 3000; c++) begin
            av0 = ($urandom_range(0, 9) < 7);
            ai0 = $urandom_range(0, 1) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
            ack0 = ($urandom_range(0, 3) == 0);
            tick();
            chk_model();
            if (c % 500 == 499) chk_all();
        end
        av0 = 1'b0; ack0 = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
